// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one mdio_ctrl engine between N requesters.
// Define MDIO_ARB_TIMEOUT_EN to add a BUSY watchdog and the sticky timeout_flag output.
module mdio_arbiter #(
  parameter int N = 3,
  parameter int TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [5*N-1:0]  req_phy_addr,
  input  logic [5*N-1:0]  req_reg_addr,
  input  logic [16*N-1:0] req_wdata,
  input  logic [2*N-1:0]  req_op,
  output logic [N-1:0]    req_ready,
  output logic [15:0]     req_rdata,
  output logic            req_error,
  output logic [N-1:0]    grant,
`ifdef MDIO_ARB_TIMEOUT_EN
  output logic            timeout_flag,
`endif
  output logic [4:0]      m_phy_addr,
  output logic [4:0]      m_reg_addr,
  output logic [15:0]     m_wdata,
  output logic [1:0]      m_op,
  output logic            m_valid,
  input  logic            m_ready,
  input  logic [15:0]     m_rdata,
  input  logic            m_error
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]    state;
  logic [PW-1:0] ptr, gidx, win_idx;
  logic          found, to_hit, done;
`ifdef MDIO_ARB_TIMEOUT_EN
  logic [15:0]   cnt;
  assign to_hit = (state == BUSY) && (cnt == 16'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif
  // first requester at or above the pointer, wrapping modulo N
  always_comb begin
    found = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win_idx = PW'((int'(ptr) + k) % N);
      end
    end
  end
  assign done      = (state == BUSY) && (m_ready || to_hit);
  assign req_ready = grant & {N{done}};
  assign req_rdata = (state == BUSY && m_ready) ? m_rdata : 16'h0000;
  assign req_error = (state == BUSY) && (m_ready ? m_error : to_hit);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      grant      <= '0;
      m_valid    <= 1'b0;
      m_phy_addr <= '0;
      m_reg_addr <= '0;
      m_wdata    <= '0;
      m_op       <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state      <= BUSY;
        gidx       <= win_idx;
        grant      <= N'(1) << win_idx;
        m_valid    <= 1'b1;
        m_phy_addr <= req_phy_addr[5*win_idx +: 5];
        m_reg_addr <= req_reg_addr[5*win_idx +: 5];
        m_wdata    <= req_wdata[16*win_idx +: 16];
        m_op       <= req_op[2*win_idx +: 2];
      end
    end else if (done) begin
      state   <= IDLE;
      grant   <= '0;
      m_valid <= 1'b0;
      ptr     <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end
`ifdef MDIO_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cnt          <= (state == BUSY) ? cnt + 16'd1 : 16'd0;
      timeout_flag <= timeout_flag | (to_hit && !m_ready);
    end
  end
`endif
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: scoreboard bench for mdio_arbiter with a bench-side mdio_ctrl responder.
module tb_mdio_arbiter;
  localparam int N = 3;
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_phy_addr, req_reg_addr;
  logic [16*N-1:0] req_wdata;
  logic [2*N-1:0]  req_op;
  logic [N-1:0]    req_ready, grant;
  logic [15:0]     req_rdata, m_wdata, m_rdata;
  logic            req_error, m_valid, m_ready, m_error;
  logic [4:0]      m_phy_addr, m_reg_addr;
  logic [1:0]      m_op;
  int passed = 0, total = 0, last_wait = 0;
  typedef struct {
    int idx; logic [4:0] ph, ra; logic [15:0] wd, rd; logic [1:0] op; logic er; int lat; bit keep;
  } item_t;
  item_t exp_q[$];
  logic [4:0] s_ph [N], s_ra [N];
  logic [15:0] s_wd [N], s_rd [N];
  logic [1:0] s_op [N];
  logic s_er [N];
  int s_lat [N];

  mdio_arbiter #(.N(N), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_phy_addr(req_phy_addr),
    .req_reg_addr(req_reg_addr), .req_wdata(req_wdata), .req_op(req_op),
    .req_ready(req_ready), .req_rdata(req_rdata), .req_error(req_error), .grant(grant),
    .m_phy_addr(m_phy_addr), .m_reg_addr(m_reg_addr), .m_wdata(m_wdata), .m_op(m_op),
    .m_valid(m_valid), .m_ready(m_ready), .m_rdata(m_rdata), .m_error(m_error)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  task automatic post(int i, logic [4:0] p, logic [4:0] r, logic [15:0] w, logic [1:0] o,
                      logic [15:0] d, logic e, int l);
    s_ph[i] = p; s_ra[i] = r; s_wd[i] = w; s_op[i] = o; s_rd[i] = d; s_er[i] = e; s_lat[i] = l;
    req_phy_addr[5*i +: 5] = p;
    req_reg_addr[5*i +: 5] = r;
    req_wdata[16*i +: 16]  = w;
    req_op[2*i +: 2]       = o;
    req_valid[i]           = 1'b1;
  endtask

  task automatic expect_grant(int i, bit k);
    item_t e;
    e.idx = i; e.ph = s_ph[i]; e.ra = s_ra[i]; e.wd = s_wd[i]; e.op = s_op[i];
    e.rd = s_rd[i]; e.er = s_er[i]; e.lat = s_lat[i]; e.keep = k;
    exp_q.push_back(e);
  endtask

  task automatic serve();
    item_t e;
    int t = 0;
    while (!m_valid && t < 100) begin @(negedge clk); t++; end
    last_wait = t;
    chk("m_valid_rise", m_valid, 1);
    if (exp_q.size() == 0) begin chk("sb_empty", 1, 0); return; end
    e = exp_q.pop_front();
    chk("grant", grant, 32'd1 << e.idx);
    chk("m_fields", {m_phy_addr, m_reg_addr, m_wdata, m_op}, {e.ph, e.ra, e.wd, e.op});
    if (!e.keep) req_valid[e.idx] = 1'b0;
    req_wdata[16*e.idx +: 16] = ~e.wd;
    req_phy_addr[5*e.idx +: 5] = ~e.ph;
    repeat (e.lat - 1) @(negedge clk);
    #1;
    chk("hold_fields", {m_phy_addr, m_reg_addr, m_wdata, m_op}, {e.ph, e.ra, e.wd, e.op});
    chk("hold_valid", m_valid, 1);
    chk("busy_rdata", req_rdata, 0);
    chk("busy_ready", req_ready, 0);
    req_wdata[16*e.idx +: 16] = e.wd;
    req_phy_addr[5*e.idx +: 5] = e.ph;
    m_ready = 1'b1; m_rdata = e.rd; m_error = e.er;
    #1;
    chk("req_ready", req_ready, 32'd1 << e.idx);
    chk("req_rdata", req_rdata, e.rd);
    chk("req_error", req_error, e.er);
    @(negedge clk);
    m_ready = 1'b0; m_rdata = 16'hbeef; m_error = 1'b1;
    #1;
    chk("post_ready", req_ready, 0);
    chk("post_rdata", req_rdata, 0);
    chk("post_error", req_error, 0);
    chk("gap_valid", m_valid, 0);
    chk("gap_grant", grant, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; req_valid = '0; req_phy_addr = '0; req_reg_addr = '0; req_wdata = '0; req_op = '0;
    m_ready = 1'b0; m_rdata = 16'hdead; m_error = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_fields", {m_phy_addr, m_reg_addr, m_wdata, m_op}, 0);
    chk("rst_ready", {req_ready, req_rdata, req_error}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    post(1, 5'd0, 5'd20, 16'h0CE6, 2'b01, 16'h0000, 1'b0, 40);
    expect_grant(1, 0);
    serve();
    chk("latency", last_wait, 1);
    m_ready = 1'b1; m_rdata = 16'h1234; m_error = 1'b1;
    #1;
    chk("idle_mready_ready", req_ready, 0);
    chk("idle_mready_data", {req_rdata, req_error}, 0);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("idle_mready_valid", {m_valid, grant}, 0);
    @(negedge clk);
    post(2, 5'd3, 5'd1, 16'h0000, 2'b10, 16'h7949, 1'b0, 5);
    expect_grant(2, 0);
    serve();
    post(0, 5'd7, 5'd31, 16'hffff, 2'b01, 16'h0000, 1'b1, 3);
    expect_grant(0, 0);
    serve();
    pulse_reset();
    post(0, 5'd1, 5'd2, 16'h1111, 2'b01, 16'h0000, 1'b0, 4);
    post(1, 5'd2, 5'd3, 16'h2222, 2'b10, 16'h5a5a, 1'b0, 6);
    post(2, 5'd4, 5'd5, 16'h3333, 2'b10, 16'ha5a5, 1'b1, 2);
    expect_grant(0, 1);
    expect_grant(1, 0);
    expect_grant(2, 0);
    expect_grant(0, 0);
    repeat (4) serve();
    pulse_reset();
    post(0, 5'd9, 5'd10, 16'h0a0a, 2'b01, 16'h0000, 1'b0, 3);
    post(2, 5'd11, 5'd12, 16'h0000, 2'b10, 16'hc0de, 1'b0, 3);
    expect_grant(0, 1);
    expect_grant(2, 0);
    expect_grant(0, 0);
    repeat (3) serve();
    post(1, 5'd13, 5'd14, 16'h4444, 2'b01, 16'h0000, 1'b0, 10);
    t = 0;
    while (!m_valid && t < 100) begin @(negedge clk); t++; end
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_fields", {m_phy_addr, m_reg_addr, m_wdata, m_op}, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    post(2, 5'd15, 5'd16, 16'h6666, 2'b01, 16'h0000, 1'b0, 2);
    post(1, 5'd13, 5'd14, 16'h4444, 2'b01, 16'h0000, 1'b0, 2);
    post(0, 5'd17, 5'd18, 16'h0000, 2'b10, 16'h8888, 1'b0, 2);
    expect_grant(0, 0);
    expect_grant(1, 0);
    expect_grant(2, 0);
    repeat (3) serve();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdio_arbiter.md
Name: mdio_arbiter

Overview:
- Shares one mdio_ctrl management engine between N independent requesters, e.g. the PHY bring-up sequencer, a link-status poller and host CSR access.
- Round-robin arbitration; one MDIO transaction in flight at a time.
- Forwards the granted requester's command to mdio_ctrl and routes completion, read data and error back to that requester only.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT, 65535, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  per-requester command valid; held high until its req_ready.
- req_phy_addr  in  5*N  PHY address; requester i uses bits [5i+4:5i].
- req_reg_addr  in  5*N  register address; requester i uses bits [5i+4:5i].
- req_wdata  in  16*N  write data; requester i uses bits [16i+15:16i].
- req_op  in  2*N  MDIO op code per requester (01 write, 10 read).
- req_ready  out  N  one-cycle completion pulse to the granted requester.
- req_rdata  out  16  read data; valid while any req_ready bit is high.
- req_error  out  1  error flag; valid while any req_ready bit is high.
- grant  out  N  one-hot current owner; 0 when idle.
- m_phy_addr  out  5  to mdio_ctrl.
- m_reg_addr  out  5  to mdio_ctrl.
- m_wdata  out  16  to mdio_ctrl.
- m_op  out  2  to mdio_ctrl.
- m_valid  out  1  to mdio_ctrl; held until m_ready.
- m_ready  in  1  from mdio_ctrl; one-cycle pulse at transaction end.
- m_rdata  in  16  from mdio_ctrl; valid with m_ready.
- m_error  in  1  from mdio_ctrl; valid with m_ready.

Behaviour:
- Reset values:
  - grant=0, m_valid=0, m_phy_addr=0, m_reg_addr=0, m_wdata=0, m_op=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - State=IDLE.
  - req_ready=0, req_rdata=0, req_error=0.
- State machine:
  - IDLE → BUSY: when any req_valid is high. Winner is the first set bit scanning upward from the pointer, wrapping modulo N. On that clock edge:
    - grant is registered one-hot.
    - The winner's phy_addr, reg_addr, wdata and op are latched into the m_* registers.
    - m_valid is set to 1.
  - Latency: req_valid high in cycle t gives m_valid high in cycle t+1.
  - BUSY: m_valid and the m_* fields are held stable. Requester inputs are ignored, so a granted requester may change its fields without effect.
  - BUSY on m_ready:
    - Combinational in the same cycle: req_ready = grant & {N{m_ready}}, req_rdata = m_rdata, req_error = m_error.
    - Registered at the following edge: m_valid=0, grant=0, pointer = (granted index + 1) mod N, state returns to IDLE.
  - IDLE lasts at least one cycle between transactions. m_valid is therefore low for at least one cycle after each m_ready, and the next m_valid rises no earlier than 2 cycles after m_ready.
  - Outside the m_ready cycle, req_rdata and req_error are 0.
- Requester contract:
  - A requester must drop req_valid in the cycle after its req_ready.
  - If req_valid is still high in IDLE, the request is treated as a new transaction and rearbitrated normally.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0. No requester waits more than N-1 transactions.
- Simultaneous events:
  - A new req_valid arriving in BUSY waits.
  - req_valid from the granted requester being dropped while BUSY does not abort the transaction; its completion is still pulsed.
- m_ready in IDLE is ignored; no req_ready is produced.
- Reset mid-transaction returns all outputs to reset values immediately. mdio_ctrl shares the same reset.

Optional Feature:
- Macro: MDIO_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit cycle counter clears on IDLE→BUSY and counts each BUSY cycle.
  - If it reaches TIMEOUT without m_ready, the arbiter pulses req_ready for the granted requester with req_error=1 and req_rdata=16'h0000.
  - It then drops m_valid and returns to IDLE with the usual pointer advance.
  - A sticky output, timeout_flag (1 bit, reset 0), sets on the first timeout.
- When not defined: no counter and no timeout_flag port; BUSY waits indefinitely for m_ready.

Test Plan:
- Single write from requester 1 (phy 0, reg 20, wdata 0x0CE6, op 01) → m_valid in the next cycle with matching fields. m_ready after 40 cycles → req_ready=3'b010 for exactly that cycle, req_error=0.
- Read from requester 2 with m_rdata=0x7949 returned → req_rdata=0x7949 only while req_ready[2]=1, otherwise 0.
- All three requesting continuously from reset → grant sequence 001,010,100,001; m_valid low ≥1 cycle between transactions.
- Requester 0 re-requests immediately after its completion while requester 2 waits → requester 2 is granted next, not requester 0.
- Assert rst while BUSY with m_valid=1 → m_valid=0 and grant=0 in the same cycle. After release, requester 0 wins first.
- With MDIO_ARB_TIMEOUT_EN and TIMEOUT=100, m_ready never asserted → req_ready pulses 100 cycles after grant with req_error=1, and timeout_flag goes high and stays high.
